// File: rtl/btn_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_decoder
// Description : Classifies a debounced button level into one-cycle events
//               (press, release, click, double click, long press) plus a
//               held level. One instance per button, directly downstream of
//               the debouncer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active-low (release must be
//                        synchronised to clk upstream)
//   btn_in       in   1  debounced level, 1 = pressed, synchronous to clk
//   press        out  1  1-cycle pulse per 0->1 of the button
//   release_evt  out  1  1-cycle pulse per 1->0 of the button
//   click        out  1  1-cycle pulse, single short press confirmed
//   dclick       out  1  1-cycle pulse, second short press released
//   long_press   out  1  1-cycle pulse when a hold reaches LONG_CYCLES
//   held         out  1  level, high while in the LONG state
// ============================================================================
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DCLICK_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic release_evt,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic held
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_down1 = 3'd1;
  localparam logic [2:0] c_wait2 = 3'd2;
  localparam logic [2:0] c_down2 = 3'd3;
  localparam logic [2:0] c_long  = 3'd4;

  localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_dclick_last = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             held_q, held_d;

  // State register, counter, input stage and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= c_idle;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_in;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  // Next-state logic. Level changes are tested before the counter limits so
  // that a press beats window expiry and a release beats the long threshold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (btn_q) state_d = c_down1;
      c_down1: begin
        if (!btn_q)                    state_d = c_wait2;
        else if (cnt_q == c_long_last) state_d = c_long;
      end
      c_wait2: begin
        if (btn_q)                        state_d = c_down2;
        else if (cnt_q == c_dclick_last) state_d = c_idle;
      end
      c_down2: begin
        if (!btn_q)                    state_d = c_idle;
        else if (cnt_q == c_long_last) state_d = c_long;
      end
      c_long:  if (!btn_q) state_d = c_idle;
      default: state_d = c_idle;
    endcase

    // Counter restarts on every state change, otherwise saturates.
    if (state_d != state_q) cnt_d = '0;
    else if (&cnt_q)        cnt_d = cnt_q;
    else                    cnt_d = cnt_q + c_cnt_one;
  end

  // Output logic: event pulses are decoded from the transition being taken
  // and registered, so every output is a flop.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      c_idle:  press_d = btn_q;
      c_down1: begin
        release_d = !btn_q;
        long_d    = btn_q && (cnt_q == c_long_last);
      end
      c_wait2: begin
        press_d = btn_q;
        click_d = !btn_q && (cnt_q == c_dclick_last);
      end
      c_down2: begin
        release_d = !btn_q;
        dclick_d  = !btn_q;
        long_d    = btn_q && (cnt_q == c_long_last);
      end
      c_long:  release_d = !btn_q;
      default: ;
    endcase
    held_d = (state_d == c_long);
  end

  assign press       = press_q;
  assign release_evt = release_q;
  assign click       = click_q;
  assign dclick      = dclick_q;
  assign long_press  = long_q;
  assign held        = held_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_decoder
// Description : Directed self-checking bench for btn_event_decoder with
//               LONG_CYCLES=20, DCLICK_CYCLES=8, CNT_W=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic press, release_evt, click, dclick, long_press, held;

  btn_event_decoder #(
    .LONG_CYCLES  (20),
    .DCLICK_CYCLES(8),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .press      (press),
    .release_evt(release_evt),
    .click      (click),
    .dclick     (dclick),
    .long_press (long_press),
    .held       (held)
  );

  always #1 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: index 0 press, 1 release, 2 click, 3 dclick, 4 long_press.
  int n_ev[5] = '{default: 0};
  int t_ev[5] = '{default: 0};
  int n_bad = 0;
  logic held_at_rel = 1'b0;

  always @(negedge clk) begin
    if (press)       begin n_ev[0] <= n_ev[0] + 1; t_ev[0] <= cyc; end
    if (release_evt) begin n_ev[1] <= n_ev[1] + 1; t_ev[1] <= cyc; held_at_rel <= held; end
    if (click)       begin n_ev[2] <= n_ev[2] + 1; t_ev[2] <= cyc; end
    if (dclick)      begin n_ev[3] <= n_ev[3] + 1; t_ev[3] <= cyc; end
    if (long_press)  begin n_ev[4] <= n_ev[4] + 1; t_ev[4] <= cyc; end
    if ((press && release_evt) || (int'(click) + int'(dclick) + int'(long_press) > 1))
      n_bad <= n_bad + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int b[5];

  task automatic run(input logic v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b = n_ev;
  endtask

  task automatic test_reset();
    int c0;
    logic any_out;
    any_out = 1'b0;
    rst = 1'b0;
    btn_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      any_out = any_out | press | release_evt | click | dclick | long_press | held;
    end
    n_cmp++; if (any_out !== 1'b0) begin n_err++; $display("FAIL reset_outputs: got %b want 0", any_out); end
    snap();
    c0 = cyc;
    rst = 1'b1;
    run(1'b1, 4);
    n_cmp++; if (n_ev[0] - b[0] != 1) begin n_err++; $display("FAIL reset_press_cnt: got %0d want 1", n_ev[0] - b[0]); end
    n_cmp++; if (t_ev[0] != c0 + 2) begin n_err++; $display("FAIL reset_press_time: got %0d want %0d", t_ev[0], c0 + 2); end
    run(1'b0, 20);
  endtask

  task automatic test_single_click();
    snap();
    run(1'b1, 5);
    run(1'b0, 20);
    n_cmp++; if (n_ev[0] - b[0] != 1) begin n_err++; $display("FAIL click_press_cnt: got %0d want 1", n_ev[0] - b[0]); end
    n_cmp++; if (n_ev[1] - b[1] != 1) begin n_err++; $display("FAIL click_rel_cnt: got %0d want 1", n_ev[1] - b[1]); end
    n_cmp++; if (n_ev[2] - b[2] != 1) begin n_err++; $display("FAIL click_cnt: got %0d want 1", n_ev[2] - b[2]); end
    n_cmp++; if (n_ev[3] - b[3] != 0) begin n_err++; $display("FAIL click_dclick_cnt: got %0d want 0", n_ev[3] - b[3]); end
    n_cmp++; if (n_ev[4] - b[4] != 0) begin n_err++; $display("FAIL click_long_cnt: got %0d want 0", n_ev[4] - b[4]); end
    n_cmp++; if (t_ev[1] - t_ev[0] != 5) begin n_err++; $display("FAIL click_rel_delay: got %0d want 5", t_ev[1] - t_ev[0]); end
    n_cmp++; if (t_ev[2] - t_ev[1] != 8) begin n_err++; $display("FAIL click_delay: got %0d want 8", t_ev[2] - t_ev[1]); end
  endtask

  task automatic test_double_click();
    snap();
    run(1'b1, 4); run(1'b0, 3); run(1'b1, 4); run(1'b0, 20);
    n_cmp++; if (n_ev[0] - b[0] != 2) begin n_err++; $display("FAIL dclick_press_cnt: got %0d want 2", n_ev[0] - b[0]); end
    n_cmp++; if (n_ev[1] - b[1] != 2) begin n_err++; $display("FAIL dclick_rel_cnt: got %0d want 2", n_ev[1] - b[1]); end
    n_cmp++; if (n_ev[3] - b[3] != 1) begin n_err++; $display("FAIL dclick_cnt: got %0d want 1", n_ev[3] - b[3]); end
    n_cmp++; if (n_ev[2] - b[2] != 0) begin n_err++; $display("FAIL dclick_click_cnt: got %0d want 0", n_ev[2] - b[2]); end
    n_cmp++; if (t_ev[3] != t_ev[1]) begin n_err++; $display("FAIL dclick_time: got %0d want %0d", t_ev[3], t_ev[1]); end
  endtask

  task automatic test_long_press();
    snap();
    run(1'b1, 25);
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL long_held_high: got %b want 1", held); end
    n_cmp++; if (n_ev[4] - b[4] != 1) begin n_err++; $display("FAIL long_cnt: got %0d want 1", n_ev[4] - b[4]); end
    n_cmp++; if (t_ev[4] - t_ev[0] != 20) begin n_err++; $display("FAIL long_delay: got %0d want 20", t_ev[4] - t_ev[0]); end
    run(1'b1, 5);
    run(1'b0, 20);
    n_cmp++; if (n_ev[1] - b[1] != 1) begin n_err++; $display("FAIL long_rel_cnt: got %0d want 1", n_ev[1] - b[1]); end
    n_cmp++; if (n_ev[2] - b[2] != 0) begin n_err++; $display("FAIL long_click_cnt: got %0d want 0", n_ev[2] - b[2]); end
    n_cmp++; if (held_at_rel !== 1'b0) begin n_err++; $display("FAIL long_held_at_rel: got %b want 0", held_at_rel); end
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL long_held_low: got %b want 0", held); end
  endtask

  task automatic test_boundaries();
    int r1;
    // Second press lands exactly on the window-expiry cycle.
    snap();
    run(1'b1, 4); run(1'b0, 8);
    r1 = t_ev[1];
    run(1'b1, 4);
    n_cmp++; if (t_ev[0] - r1 != 8) begin n_err++; $display("FAIL edge_press_time: got %0d want 8", t_ev[0] - r1); end
    run(1'b0, 20);
    n_cmp++; if (n_ev[2] - b[2] != 0) begin n_err++; $display("FAIL edge_click_cnt: got %0d want 0", n_ev[2] - b[2]); end
    n_cmp++; if (n_ev[3] - b[3] != 1) begin n_err++; $display("FAIL edge_dclick_cnt: got %0d want 1", n_ev[3] - b[3]); end
    // One cycle later: the window has closed, so two separate clicks.
    snap();
    run(1'b1, 4); run(1'b0, 9); run(1'b1, 4); run(1'b0, 20);
    n_cmp++; if (n_ev[2] - b[2] != 2) begin n_err++; $display("FAIL late_click_cnt: got %0d want 2", n_ev[2] - b[2]); end
    n_cmp++; if (n_ev[3] - b[3] != 0) begin n_err++; $display("FAIL late_dclick_cnt: got %0d want 0", n_ev[3] - b[3]); end
    // Release on the cnt==19 cycle beats the long press.
    snap();
    run(1'b1, 20); run(1'b0, 20);
    n_cmp++; if (n_ev[4] - b[4] != 0) begin n_err++; $display("FAIL rel19_long_cnt: got %0d want 0", n_ev[4] - b[4]); end
    n_cmp++; if (n_ev[2] - b[2] != 1) begin n_err++; $display("FAIL rel19_click_cnt: got %0d want 1", n_ev[2] - b[2]); end
    n_cmp++; if (t_ev[1] - t_ev[0] != 20) begin n_err++; $display("FAIL rel19_rel_delay: got %0d want 20", t_ev[1] - t_ev[0]); end
    // One cycle longer reaches the long press.
    snap();
    run(1'b1, 21); run(1'b0, 20);
    n_cmp++; if (n_ev[4] - b[4] != 1) begin n_err++; $display("FAIL hold21_long_cnt: got %0d want 1", n_ev[4] - b[4]); end
    n_cmp++; if (n_ev[2] - b[2] != 0) begin n_err++; $display("FAIL hold21_click_cnt: got %0d want 0", n_ev[2] - b[2]); end
  endtask

  task automatic test_reset_mid_wait();
    snap();
    run(1'b1, 4); run(1'b0, 2);
    rst = 1'b0;
    run(1'b0, 1);
    n_cmp++; if ({press, release_evt, click, dclick, long_press, held} !== 6'b0) begin
      n_err++; $display("FAIL midrst_outputs: got %b want 000000", {press, release_evt, click, dclick, long_press, held});
    end
    rst = 1'b1;
    run(1'b0, 20);
    n_cmp++; if (n_ev[2] - b[2] != 0) begin n_err++; $display("FAIL midrst_click_cnt: got %0d want 0", n_ev[2] - b[2]); end
    n_cmp++; if (n_ev[1] - b[1] != 1) begin n_err++; $display("FAIL midrst_rel_cnt: got %0d want 1", n_ev[1] - b[1]); end
    snap();
    run(1'b1, 5); run(1'b0, 20);
    n_cmp++; if (n_ev[0] - b[0] != 1) begin n_err++; $display("FAIL midrst_next_press: got %0d want 1", n_ev[0] - b[0]); end
    n_cmp++; if (n_ev[2] - b[2] != 1) begin n_err++; $display("FAIL midrst_next_click: got %0d want 1", n_ev[2] - b[2]); end
    n_cmp++; if (n_ev[3] - b[3] != 0) begin n_err++; $display("FAIL midrst_next_dclick: got %0d want 0", n_ev[3] - b[3]); end
  endtask

  task automatic test_exclusive();
    n_cmp++; if (n_bad != 0) begin n_err++; $display("FAIL coincident_events: got %0d want 0", n_bad); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_boundaries();
    test_reset_mid_wait();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
